// File: rtl/alu_pkg.sv
// Shared widths and operation codes for the execute-stage ALU.
// Imported by the combinational mux and its registered wrapper.
package alu_pkg;

   localparam int DATA_W  = 32;
   localparam int CTRL_W  = 4;
   localparam int SHAMT_W = 5;

   localparam logic [CTRL_W-1:0] ALU_ADD   = 4'b0000;
   localparam logic [CTRL_W-1:0] ALU_SUB   = 4'b0001;
   localparam logic [CTRL_W-1:0] ALU_AND   = 4'b0010;
   localparam logic [CTRL_W-1:0] ALU_OR    = 4'b0011;
   localparam logic [CTRL_W-1:0] ALU_XOR   = 4'b0100;
   localparam logic [CTRL_W-1:0] ALU_NOR   = 4'b0101;
   localparam logic [CTRL_W-1:0] ALU_SLT   = 4'b0110;
   localparam logic [CTRL_W-1:0] ALU_SLTU  = 4'b0111;
   localparam logic [CTRL_W-1:0] ALU_SLL   = 4'b1000;
   localparam logic [CTRL_W-1:0] ALU_SRL   = 4'b1001;
   localparam logic [CTRL_W-1:0] ALU_SRA   = 4'b1010;
   localparam logic [CTRL_W-1:0] ALU_LUI   = 4'b1011;
   localparam logic [CTRL_W-1:0] ALU_PASSA = 4'b1100;
   localparam logic [CTRL_W-1:0] ALU_PASSB = 4'b1101;

endpackage

// File: rtl/alu_comb.sv
// Combinational 14-operation mux around one shared adder/subtractor.
// Zero latency; no backpressure, result follows inputs continuously.
module alu_comb
   import alu_pkg::*;
(
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   input  logic [CTRL_W-1:0] aluc,
   output logic [DATA_W-1:0] result
);

   logic                 w_sub;
   logic [DATA_W-1:0]    w_b_op;
   logic [DATA_W:0]      w_sum;
   logic [SHAMT_W-1:0]   w_shamt;
   logic                 w_lt_signed;
   logic                 w_lt_unsigned;
   logic [DATA_W-1:0]    w_sra;

   assign w_sub   = (aluc == ALU_SUB) || (aluc == ALU_SLT) || (aluc == ALU_SLTU);
   assign w_b_op  = w_sub ? ~b : b;
   assign w_sum   = {1'b0, a} + {1'b0, w_b_op} + {{DATA_W{1'b0}}, w_sub};
   assign w_shamt = a[SHAMT_W-1:0];

   // Differing signs decide by a's sign alone, so a-b overflow cannot flip SLT.
   assign w_lt_signed   = (a[DATA_W-1] ^ b[DATA_W-1]) ? a[DATA_W-1] : w_sum[DATA_W-1];
   // a + ~b + 1 carries out exactly when a >= b.
   assign w_lt_unsigned = ~w_sum[DATA_W];
   assign w_sra         = DATA_W'($signed(b) >>> w_shamt);

   always_comb begin
      result = '0;
      case (aluc)
         ALU_ADD,
         ALU_SUB:   result = w_sum[DATA_W-1:0];
         ALU_AND:   result = a & b;
         ALU_OR:    result = a | b;
         ALU_XOR:   result = a ^ b;
         ALU_NOR:   result = ~(a | b);
         ALU_SLT:   result = {{(DATA_W-1){1'b0}}, w_lt_signed};
         ALU_SLTU:  result = {{(DATA_W-1){1'b0}}, w_lt_unsigned};
         ALU_SLL:   result = b << w_shamt;
         ALU_SRL:   result = b >> w_shamt;
         ALU_SRA:   result = w_sra;
         ALU_LUI:   result = {b[15:0], 16'h0000};
         ALU_PASSA: result = a;
         ALU_PASSB: result = b;
         default:   result = '0;
      endcase
   end

endmodule

// File: rtl/alu_unit.sv
// Registered 32-bit ALU: result and zero flag loaded every clock edge.
// Latency 1 cycle; no backpressure, accepts a new operation every cycle.
module alu_unit
   import alu_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   input  logic [CTRL_W-1:0] aluc,
   output logic [DATA_W-1:0] r,
   output logic              z
);

   logic [DATA_W-1:0] w_result;
   logic [DATA_W-1:0] r_result;
   logic              r_zero;

   alu_comb u_alu_comb (
      .a      (a),
      .b      (b),
      .aluc   (aluc),
      .result (w_result)
   );

   // Zero flag comes from the same value loaded into r_result so they never disagree.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_result <= '0;
         r_zero   <= 1'b1;
      end else begin
         r_result <= w_result;
         r_zero   <= (w_result == '0);
      end
   end

   assign r = r_result;
   assign z = r_zero;

endmodule

// File: tb/tb_alu_unit.sv
// Directed and randomized checks of alu_unit against an arithmetic reference model.
module tb_alu_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] a;
   logic [31:0] b;
   logic [3:0]  aluc;
   logic [31:0] r;
   logic        z;

   int checks = 0;
   int errors = 0;

   alu_unit dut (
      .clk  (clk),
      .rst  (rst),
      .a    (a),
      .b    (b),
      .aluc (aluc),
      .r    (r),
      .z    (z)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] ref_alu(input logic [31:0] x, input logic [31:0] y,
                                           input logic [3:0] op);
      int unsigned sh;
      sh = x % 32;
      case (op)
         4'd0:  return x + y;
         4'd1:  return x - y;
         4'd2:  return x & y;
         4'd3:  return x | y;
         4'd4:  return x ^ y;
         4'd5:  return ~(x | y);
         4'd6:  return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
         4'd7:  return (x < y) ? 32'd1 : 32'd0;
         4'd8:  return y << sh;
         4'd9:  return y >> sh;
         4'd10: return y[31] ? ~((~y) >> sh) : (y >> sh);
         4'd11: return y * 32'd65536;
         4'd12: return x;
         4'd13: return y;
         default: return 32'd0;
      endcase
   endfunction

   // Drive one operation, let one edge pass, then sample clear of the edge.
   task automatic step(input logic [31:0] ia, input logic [31:0] ib,
                       input logic [3:0] ic, input logic irst);
      a    = ia;
      b    = ib;
      aluc = ic;
      rst  = irst;
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] exp_r, input logic exp_z);
      checks++;
      assert (r === exp_r) else begin
         errors++;
         $error("FAIL %s r=%h expected %h", tag, r, exp_r);
      end
      checks++;
      assert (z === exp_z) else begin
         errors++;
         $error("FAIL %s z=%b expected %b", tag, z, exp_z);
      end
   endtask

   task automatic op_check(input string tag, input logic [31:0] ia, input logic [31:0] ib,
                           input logic [3:0] ic, input logic [31:0] exp_r);
      step(ia, ib, ic, 1'b0);
      check(tag, exp_r, exp_r == 32'd0);
   endtask

   initial begin
      logic [31:0] sweep_exp [16];
      logic [31:0] ra;
      logic [31:0] rb;
      logic [3:0]  rc;
      logic [31:0] e;

      sweep_exp = '{32'h3, 32'hFFFFFFFF, 32'h0, 32'h3, 32'h3, 32'hFFFFFFFC, 32'h1, 32'h1,
                    32'h4, 32'h1, 32'h1, 32'h00020000, 32'h1, 32'h2, 32'h0, 32'h0};

      // Reset held two edges, then release
      step(32'd1, 32'd2, 4'd0, 1'b1);
      check("reset_edge1", 32'd0, 1'b1);
      step(32'd1, 32'd2, 4'd0, 1'b1);
      check("reset_edge2", 32'd0, 1'b1);
      op_check("reset_release", 32'd1, 32'd2, 4'd0, 32'd3);

      for (int i = 0; i < 16; i++) begin
         op_check($sformatf("sweep_%0d", i), 32'd1, 32'd2, 4'(i), sweep_exp[i]);
      end

      op_check("slt_neg",  32'hFFFFFFFF, 32'd1, 4'd6, 32'd1);
      op_check("sltu_big", 32'hFFFFFFFF, 32'd1, 4'd7, 32'd0);
      op_check("sub_neg",  32'hFFFFFFFF, 32'd1, 4'd1, 32'hFFFFFFFE);
      op_check("add_wrap", 32'hFFFFFFFF, 32'd1, 4'd0, 32'd0);

      op_check("sra_31",   32'd31, 32'h80000000, 4'd10, 32'hFFFFFFFF);
      op_check("srl_31",   32'd31, 32'h80000000, 4'd9,  32'd1);
      op_check("sll_wrap", 32'h21, 32'd1,        4'd8,  32'd2);

      op_check("slt_ovf",  32'h7FFFFFFF, 32'h80000000, 4'd6, 32'd0);
      op_check("sub_ovf",  32'h7FFFFFFF, 32'h80000000, 4'd1, 32'hFFFFFFFF);
      op_check("add_ovf",  32'h7FFFFFFF, 32'd1,        4'd0, 32'h80000000);

      // Continuous random stream with a single-edge reset in the middle
      for (int n = 0; n < 300; n++) begin
         ra = $urandom;
         rb = $urandom;
         rc = 4'($urandom_range(0, 15));
         case ($urandom_range(0, 5))
            0: ra = ra & 32'h0000003F;
            1: rb = {rb[31], 31'h0} | (rb & 32'h7FFFFFFF & {32{ra[0]}});
            2: rb = ra;
            default: ;
         endcase
         if (n == 150) begin
            step(ra, rb, rc, 1'b1);
            check("midstream_reset", 32'd0, 1'b1);
         end else begin
            e = ref_alu(ra, rb, rc);
            step(ra, rb, rc, 1'b0);
            check($sformatf("rand_%0d_op%0d", n, rc), e, e == 32'd0);
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
